// File: rtl/somador_multiciclo.sv
// Multi-cycle ripple adder: CHUNK bits per clock, valid/ready on both sides.
// Optional subtract mode enabled by defining SUBTRACAO_EN (adds port sub).
module somador_multiciclo #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACAO_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SOMA,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CHUNK:0]   slice_sum;
    logic             last;

    // B is stored already inverted in subtract mode, so the slice adder never sees sub
`ifdef SUBTRACAO_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    assign a_sh      = a_q >> (int'(k_q) * CHUNK);
    assign b_sh      = b_q >> (int'(k_q) * CHUNK);
    assign slice_sum = {1'b0, a_sh[CHUNK-1:0]}
                     + {1'b0, b_sh[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
    assign last      = (k_q == KW'(N - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        k_d     = k_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = c_eff;
                    k_d     = '0;
                    state_d = SOMA;
                end
            end
            SOMA: begin
                s_d[int'(k_q)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                carry_d = slice_sum[CHUNK];
                k_d     = k_q + KW'(1);
                if (last) begin
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                           && (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_somador_multiciclo.sv
// Directed bench for somador_multiciclo: 16/4 default instance plus a
// single-cycle 4/4 instance sharing the clock.
module tb_somador_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin;
    logic        sub_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout, ovf;

    logic        v4, r4, c4, ov4, co4, of4;
    logic [3:0]  a4, b4, s4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    somador_multiciclo #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SUBTRACAO_EN
        .sub(sub_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    somador_multiciclo #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4),
        .a(a4), .b(b4), .cin(c4),
`ifdef SUBTRACAO_EN
        .sub(1'b0),
`endif
        .out_valid(ov4), .out_ready(1'b1),
        .s(s4), .cout(co4), .ovf(of4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic tc, input logic [15:0] es,
                         input logic ec, input logic eo, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~tc;
        wait_out(lat);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk);
    endtask

    initial begin
        int lat;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        sub_i = 1'b0; out_ready = 1'b1;
        v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst4_s", 32'(s4), 32'd0);
        rst_n = 1'b1;

        do_op(16'd5, 16'd3, 1'b0, 16'd8, 1'b0, 1'b0, "add5_3");
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "povf");
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "novf");
        do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "mix");

        // back-pressure: result held while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        a = 16'd4; b = 16'd2; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a = 16'd100; b = 16'd100; cin = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_s", 32'(s), 32'd7);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        a = 16'd1; b = 16'd1; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept", 32'(in_ready), 32'd0);
        wait_out(lat);
        check("bp2_lat", 32'(lat), 32'd4);
        check("bp2_s", 32'(s), 32'd2);
        @(posedge clk);

        // reset two edges into an operation
        @(negedge clk);
        a = 16'd9; b = 16'd9; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_idle", 32'(in_ready), 32'd1);
        do_op(16'd10, 16'd8, 1'b0, 16'd18, 1'b0, 1'b0, "after_rst");

`ifdef SUBTRACAO_EN
        sub_i = 1'b1;
        do_op(16'd5, 16'd8, 1'b0, 16'hFFFD, 1'b0, 1'b0, "sub5_8");
        do_op(16'd8, 16'd5, 1'b0, 16'd3, 1'b1, 1'b0, "sub8_5");
        sub_i = 1'b0;
        do_op(16'd8, 16'd5, 1'b0, 16'd13, 1'b0, 1'b0, "nosub");
`endif

        // single-cycle instance
        @(negedge clk);
        check("w4_rdy", 32'(r4), 32'd1);
        a4 = 4'd10; b4 = 4'd8; c4 = 1'b0; v4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w4_valid", 32'(ov4), 32'd1);
        check("w4_s", 32'(s4), 32'd2);
        check("w4_cout", 32'(co4), 32'd1);
        check("w4_ovf", 32'(of4), 32'd1);
        @(posedge clk);
        @(negedge clk);
        a4 = 4'd7; b4 = 4'd0; c4 = 1'b1; v4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w4b_valid", 32'(ov4), 32'd1);
        check("w4b_s", 32'(s4), 32'd8);
        check("w4b_cout", 32'(co4), 32'd0);
        check("w4b_ovf", 32'(of4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
